// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/exec control sequencer for a two-register ALU datapath
// All outputs come straight from flops; decode results are captured on the fetch handshake.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [7:0] lit,
  input  logic       z,
  input  logic       n,
  output logic       instr_req,
  output logic [7:0] pc,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic [2:0] alu_op,
  output logic       load_a,
  output logic       load_b,
  output logic [7:0] im_out,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [6:0] ir_q, ir_d;
  logic [7:0] im_q, im_d;
  logic       instr_req_q, instr_req_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       halted_q, halted_d;

  logic       ir_is_alu;
  logic       ir_is_halt;
  logic       jump_taken;
  logic [6:0] fetch_ctrl;

  // {sel_a, sel_b, alu_op} for an opcode, given its upper five bits
  function automatic logic [6:0] decode_ctrl(input logic [4:0] op_hi);
    logic [6:0] c;
    case (op_hi[4:3])
      2'b00:   c = {2'b00, 2'b00, op_hi[2:0]};
      2'b01:   c = {2'b00, 2'b10, op_hi[2:0]};
      default: c = {2'b01, 2'b01, 3'b000};
    endcase
    return c;
  endfunction

  always_comb begin
    ir_is_alu  = (ir_q[6] == 1'b0);
    ir_is_halt = (ir_q[6:5] == 2'b11) && (ir_q[4:0] == 5'h1f);
    fetch_ctrl = decode_ctrl(opcode[6:2]);
    case (ir_q[1:0])
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = z;
      2'b10:   jump_taken = n;
      default: jump_taken = 1'b0;
    endcase

    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    im_d        = im_q;
    instr_req_d = 1'b0;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    alu_op_d    = alu_op_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    halted_d    = halted_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d     = FETCH;
          instr_req_d = 1'b1;
        end
      end
      FETCH: begin
        instr_req_d = 1'b1;
        if (instr_valid) begin
          state_d                       = DECODE;
          instr_req_d                   = 1'b0;
          ir_d                          = opcode;
          im_d                          = lit;
          {sel_a_d, sel_b_d, alu_op_d}  = fetch_ctrl;
        end
      end
      DECODE: begin
        state_d  = EXEC;
        load_a_d = ir_is_alu && !ir_q[1];
        load_b_d = ir_is_alu &&  ir_q[1];
      end
      EXEC: begin
        sel_a_d  = 2'b00;
        sel_b_d  = 2'b00;
        alu_op_d = 3'b000;
        if (ir_q[6:5] == 2'b10 && jump_taken) begin
          pc_d = im_q;
        end else if (!ir_is_halt) begin
          pc_d = pc_q + 8'd1;
        end
        if (ir_is_halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (run) begin
          state_d     = FETCH;
          instr_req_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= 8'h00;
      ir_q        <= 7'h00;
      im_q        <= 8'h00;
      instr_req_q <= 1'b0;
      sel_a_q     <= 2'b00;
      sel_b_q     <= 2'b00;
      alu_op_q    <= 3'b000;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      im_q        <= im_d;
      instr_req_q <= instr_req_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      alu_op_q    <= alu_op_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      halted_q    <= halted_d;
    end
  end

  assign instr_req = instr_req_q;
  assign pc        = pc_q;
  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign alu_op    = alu_op_q;
  assign load_a    = load_a_q;
  assign load_b    = load_b_q;
  assign im_out    = im_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// Driver pushes per-instruction expectations; a monitor keyed on the fetch handshake checks them.
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [7:0] lit;
  logic       z;
  logic       n;
  logic       instr_req;
  logic [7:0] pc;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [2:0] alu_op;
  logic       load_a;
  logic       load_b;
  logic [7:0] im_out;
  logic       halted;

  control_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .lit         (lit),
    .z           (z),
    .n           (n),
    .instr_req   (instr_req),
    .pc          (pc),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .alu_op      (alu_op),
    .load_a      (load_a),
    .load_b      (load_b),
    .im_out      (im_out),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc_before;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [2:0] alu_op;
    logic [7:0] im;
    logic       la;
    logic       lb;
    logic [7:0] pc_after;
    logic       halt;
    logic       fetch_next;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_pc;
  logic       mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics written directly from the opcode table
  function automatic exp_t model(input logic [7:0] cur_pc, input logic [6:0] op, input logic [7:0] l,
                                 input logic zz, input logic nn, input logic rn);
    exp_t e;
    int   cls;
    int   sub;
    cls = int'(op[6:5]);
    sub = int'(op[1:0]);
    e.pc_before = cur_pc;
    e.im        = l;
    e.halt      = 1'b0;
    e.la        = 1'b0;
    e.lb        = 1'b0;
    e.pc_after  = 8'((int'(cur_pc) + 1) % 256);
    if (cls <= 1) begin
      e.sel_a  = 2'd0;
      e.sel_b  = (cls == 1) ? 2'd2 : 2'd0;
      e.alu_op = op[4:2];
      e.la     = (op[1] == 1'b0);
      e.lb     = (op[1] == 1'b1);
    end else begin
      e.sel_a  = 2'd1;
      e.sel_b  = 2'd1;
      e.alu_op = 3'd0;
      if (cls == 2) begin
        if (sub == 0 || (sub == 1 && zz) || (sub == 2 && nn)) e.pc_after = l;
      end else if (op[4:0] == 5'd31) begin
        e.halt     = 1'b1;
        e.pc_after = cur_pc;
      end
    end
    e.fetch_next = rn && !e.halt;
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [7:0] l, input logic zz, input logic nn,
                       input int stall, input logic run_after);
    exp_t e;
    int   waitc;
    run         = 1'b1;
    instr_valid = 1'b0;
    waitc       = 0;
    while (!instr_req && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!instr_req) begin
      check("fetch_timeout", 32'(instr_req), 32'd1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      opcode = 7'($urandom);
      lit    = 8'($urandom);
      check("stall_req", 32'(instr_req), 32'd1);
      check("stall_loads", 32'({load_a, load_b}), 32'd0);
      check("stall_pc", 32'(pc), 32'(model_pc));
      @(posedge clk); #1;
    end
    e = model(model_pc, op, l, zz, nn, run_after);
    sb_q.push_back(e);
    model_pc    = e.pc_after;
    opcode      = op;
    lit         = l;
    z           = zz;
    n           = nn;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'($urandom);
    opcode      = 7'($urandom);
    lit         = 8'($urandom);
    run         = run_after;
    @(posedge clk); #1;
    instr_valid = 1'($urandom);
    opcode      = 7'($urandom);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Monitor: a fetch handshake starts a 3-phase comparison against the oldest expectation
  initial begin
    exp_t cur;
    logic post_pending;
    post_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (post_pending) begin
        post_pending = 1'b0;
        check("post_pc", 32'(pc), 32'(cur.pc_after));
        check("post_halted", 32'(halted), 32'(cur.halt));
        check("post_req", 32'(instr_req), 32'(cur.fetch_next));
        check("post_loads", 32'({load_a, load_b}), 32'd0);
      end
      if (mon_en && rst_n && instr_req && instr_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          cur = sb_q.pop_front();
          check("fetch_pc", 32'(pc), 32'(cur.pc_before));
          @(negedge clk);
          check("dec_sel_a", 32'(sel_a), 32'(cur.sel_a));
          check("dec_sel_b", 32'(sel_b), 32'(cur.sel_b));
          check("dec_alu_op", 32'(alu_op), 32'(cur.alu_op));
          check("dec_im_out", 32'(im_out), 32'(cur.im));
          check("dec_loads", 32'({load_a, load_b}), 32'd0);
          check("dec_req", 32'(instr_req), 32'd0);
          @(negedge clk);
          check("exec_sel_a", 32'(sel_a), 32'(cur.sel_a));
          check("exec_sel_b", 32'(sel_b), 32'(cur.sel_b));
          check("exec_alu_op", 32'(alu_op), 32'(cur.alu_op));
          check("exec_load_a", 32'(load_a), 32'(cur.la));
          check("exec_load_b", 32'(load_b), 32'(cur.lb));
          check("exec_pc", 32'(pc), 32'(cur.pc_before));
          post_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] rop;
    logic [7:0] frozen;
    mon_en      = 1'b1;
    model_pc    = 8'h00;
    rst_n       = 1'b0;
    run         = 1'b0;
    instr_valid = 1'b0;
    opcode      = 7'h00;
    lit         = 8'h00;
    z           = 1'b0;
    n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_sel", 32'({sel_a, sel_b, alu_op}), 32'd0);
    check("rst_loads", 32'({load_a, load_b}), 32'd0);
    check("rst_im_halted", 32'({im_out, halted}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_run", 32'(instr_req), 32'd0);

    issue(7'b0100110, 8'h2A, 1'b0, 1'b0, 0, 1'b1);
    issue(7'b0001001, 8'h33, 1'b0, 1'b0, 4, 1'b1);
    issue(7'b1000001, 8'h80, 1'b1, 1'b0, 0, 1'b1);
    issue(7'b1000001, 8'h20, 1'b0, 1'b1, 1, 1'b1);
    issue(7'b1000010, 8'h10, 1'b0, 1'b1, 0, 1'b1);
    issue(7'b1000011, 8'h55, 1'b1, 1'b1, 0, 1'b1);
    issue(7'b1000000, 8'hFF, 1'b0, 1'b0, 2, 1'b1);
    issue(7'b0011110, 8'h01, 1'b0, 1'b0, 0, 1'b1);
    issue(7'b1100000, 8'h07, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rop = 7'($urandom);
      if (rop == 7'h7F) rop = 7'h7E;
      if (i % 10 == 3) rop = {2'b10, 3'($urandom), 2'($urandom)};
      issue(rop, 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0));
    end

    frozen = model_pc;
    issue(7'h7F, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run         = 1'($urandom);
      instr_valid = 1'($urandom);
      opcode      = 7'($urandom);
      @(posedge clk); #1;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_pc", 32'(pc), 32'(frozen));
      check("halt_outs", 32'({instr_req, load_a, load_b, sel_a, sel_b, alu_op}), 32'd0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", 32'(pc), 32'd0);
    check("halt_rst_halted", 32'(halted), 32'd0);
    run         = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk); #3;
    rst_n    = 1'b1;
    model_pc = 8'h00;
    @(posedge clk); #1;
    check("rst_idle_req", 32'(instr_req), 32'd0);

    issue(7'b0000100, 8'h11, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    mon_en = 1'b0;
    run    = 1'b1;
    @(posedge clk); #1;
    check("midop_req", 32'(instr_req), 32'd1);
    opcode      = 7'b0000000;
    lit         = 8'h99;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_exec_load_a", 32'(load_a), 32'd1);
    check("midop_exec_pc", 32'(pc), 32'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check("midop_rst_loads", 32'({load_a, load_b}), 32'd0);
    check("midop_rst_pc", 32'(pc), 32'd0);
    check("midop_rst_outs", 32'({instr_req, sel_a, sel_b, alu_op, im_out}), 32'd0);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midop_idle_req", 32'(instr_req), 32'd0);
    check("midop_idle_pc", 32'(pc), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be as listed in REQ-002 to REQ-014.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset, asserted low, asynchronous assertion.
REQ-004 run  in  1  start/continue execution; sampled in IDLE and at the end of EXEC.
REQ-005 instr_valid  in  1  instruction memory response valid; opcode/lit valid this cycle.
REQ-006 opcode  in  7  instruction opcode.
REQ-007 lit  in  8  instruction literal (immediate or jump target).
REQ-008 z, n  in  1 each  zero/negative status flags from the ALU status register.
REQ-009 instr_req  out  1  instruction fetch request at address pc.
REQ-010 pc  out  8  program counter.
REQ-011 sel_a  out  2  operand-A mux select: 00 = reg A, 01 = zero. Values 10 and 11 are never driven.
REQ-012 sel_b  out  2  operand-B mux select: 00 = reg B, 01 = zero, 10 = immediate (im_out = IR literal). Value 11 is never driven.
REQ-013 alu_op  out  3  ALU function; load_a, load_b  out  1 each  register write enables.
REQ-014 im_out  out  8  latched literal; halted  out  1  HALT reached.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALT, with binary encoding.
REQ-016 IDLE: in IDLE the block SHALL go to FETCH when run=1 and otherwise stay in IDLE.
REQ-017 FETCH: in FETCH the block SHALL hold instr_req=1 until instr_valid=1, then latch opcode into IR and lit into im_out, and go to DECODE. The wait is unbounded.
REQ-018 DECODE: DECODE SHALL last exactly 1 cycle. In DECODE the block SHALL drive sel_a, sel_b and alu_op from IR, and SHALL then go to EXEC.
REQ-019 EXEC: EXEC SHALL last exactly 1 cycle. In EXEC the block SHALL keep sel_a, sel_b and alu_op stable, assert at most one load strobe, and update pc.
REQ-020 After EXEC the next state SHALL be FETCH if run=1, otherwise IDLE. A HALT instruction SHALL instead go to HALT.
REQ-021 Opcode decoding SHALL use opcode[6:5] as the class: 00 ALU register-register, 01 ALU immediate, 10 jump, 11 special.
REQ-022 For ALU classes: alu_op = opcode[4:2]. opcode[1] selects the destination (0 asserts load_a, 1 asserts load_b) in EXEC only. sel_a = 00. sel_b = 00 for class 00 and 10 for class 01.
REQ-023 For jump class, opcode[1:0] SHALL select: 00 JMP (always), 01 JEQ (taken when z=1), 10 JLT (taken when n=1), 11 NOP.
REQ-024 Jump flags SHALL be sampled in EXEC. When taken, pc <= lit latch; otherwise pc <= pc+1.
REQ-025 For jump and special classes: sel_a = 01, sel_b = 01, alu_op = 000, and no load strobe is asserted.
REQ-026 Special class: opcode[4:0]=11111 is HALT and SHALL not change pc. All other special-class encodings are NOP (pc+1).
REQ-027 Non-jump instructions SHALL set pc <= pc+1, modulo 256 (255 wraps to 0, no flag). A taken jump to its own address is legal and loops.
REQ-028 Minimum instruction latency SHALL be 3 cycles (FETCH, DECODE, EXEC). Each extra cycle with instr_valid=0 in FETCH adds 1 cycle.
REQ-029 instr_valid outside FETCH SHALL be ignored. opcode and lit SHALL only be sampled in the FETCH cycle where instr_valid=1.
REQ-030 In HALT: halted=1, all outputs held inactive, pc frozen. The only exit from HALT SHALL be rst_n.
REQ-031 All outputs SHALL be registered or decoded from state and IR only. No combinational path SHALL exist from the inputs to the outputs.

Reset
REQ-032 When rst_n=0 the block SHALL immediately enter IDLE, regardless of clk.
REQ-033 On reset: pc=0, IR=0, im_out=0, instr_req=0, load_a=0, load_b=0, sel_a=00, sel_b=00, alu_op=000, halted=0.
REQ-034 Reset during any state, including EXEC, SHALL abort the instruction with no load strobe and no pc update.
REQ-035 Reset deassertion SHALL be synchronized externally. The first active edge after deassertion SHALL evaluate IDLE.

Verification
REQ-036 ALU immediate: run=1; opcode=0100110 (class 01, alu_op=001, dest B), lit=0x2A, instr_valid=1 in the first FETCH cycle -> in DECODE sel_b=10, im_out=0x2A, alu_op=001; in EXEC load_b=1 for 1 cycle; then pc=1 and FETCH.
REQ-037 Fetch stall: instr_valid held 0 for 4 cycles -> instr_req=1 throughout, pc unchanged, no strobes; the instruction completes 7 cycles after entering FETCH.
REQ-038 Conditional jumps: JEQ (opcode 1000001), lit=0x80, z=1 -> pc=0x80. Same with z=0 -> pc=pc+1. JLT with n=1 -> jump taken.
REQ-039 PC wrap: at pc=0xFF execute an ALU op -> pc=0x00 and execution continues.
REQ-040 HALT (opcode 1111111) -> halted=1 after EXEC, pc frozen; run and instr_valid toggling has no effect; rst_n low -> IDLE, pc=0, halted=0.
REQ-041 Mid-op reset: rst_n pulsed low during EXEC of an ALU register-register op -> no load strobe, pc=0, IDLE; run=0 after EXEC -> return to IDLE.
